alu_checker: RTL and testbench

ALU_CHECKER -- requirements
Module: alu_checker

---
 rtl/alu_checker_if.sv | 29 ++
 rtl/alu_checker.sv | 126 ++++++++++++
 tb/tb_alu_checker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_checker_if.sv
// Bundle of stimulus, observed-ALU and result signals for alu_checker.
// master drives samples and start; slave is the checker itself.
interface alu_checker_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [7:0]             num_checks;
    logic                   sample_valid;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2:0]             op_code;
    logic [WIDTH-1:0]       alu_out;
    logic                   busy;
    logic                   done;
    logic [7:0]             pass_cnt;
    logic [7:0]             fail_cnt;
    logic                   err_flag;
    logic [3+4*WIDTH-1:0]   err_info;

    modport master (
        output start, num_checks, sample_valid, a, b, op_code, alu_out,
        input  busy, done, pass_cnt, fail_cnt, err_flag, err_info
    );

    modport slave (
        input  start, num_checks, sample_valid, a, b, op_code, alu_out,
        output busy, done, pass_cnt, fail_cnt, err_flag, err_info
    );
endinterface

// File: rtl/alu_checker.sv
// Two-stage ALU result checker: capture a sample, then compare it
// against a reference model and tally pass/fail over a run.
module alu_checker #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    alu_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         remaining;
    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [2:0]         s1_op;
    logic [WIDTH-1:0]   s1_out;
    logic [7:0]         pass_cnt;
    logic [7:0]         fail_cnt;
    logic               err_flag;
    logic [3+4*WIDTH-1:0] err_info;
    logic               busy;
    logic               done;
    logic               accept;
    logic               capture;
    logic [WIDTH-1:0]   expected;

    function automatic logic [WIDTH-1:0] ref_result(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~x;
            3'd6: r = x << 1;
            3'd7: r = x >> 1;
        endcase
        return r;
    endfunction

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign capture  = bus.sample_valid && (state == RUN);
    assign expected = ref_result(s1_op, s1_a, s1_b);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (bus.start)
                    state_next = (bus.num_checks == 8'd0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (capture && remaining == 8'd1)
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // leave only after the last stage-2 compare has landed
                if (!s1_valid)
                    state_next = DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_out    <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err_flag  <= 1'b0;
            err_info  <= '0;
        end else begin
            state    <= state_next;
            s1_valid <= capture;
            if (capture) begin
                s1_a      <= bus.a;
                s1_b      <= bus.b;
                s1_op     <= bus.op_code;
                s1_out    <= bus.alu_out;
                remaining <= remaining - 8'd1;
            end
            if (accept) begin
                remaining <= bus.num_checks;
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                err_flag  <= 1'b0;
                err_info  <= '0;
            end else if (s1_valid) begin
                if (s1_out == expected) begin
                    pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    fail_cnt <= fail_cnt + 8'd1;
                    if (!err_flag) begin
                        err_flag <= 1'b1;
                        err_info <= {s1_op, s1_a, s1_b, s1_out, expected};
                    end
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass_cnt = pass_cnt;
    assign bus.fail_cnt = fail_cnt;
    assign bus.err_flag = err_flag;
    assign bus.err_info = err_info;
endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker with hand-computed expected values.
module tb_alu_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_checker_if #(.WIDTH(8)) bus ();

    alu_checker #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] n);
        bus.start      = 1'b1;
        bus.num_checks = n;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] res);
        bus.sample_valid = 1'b1;
        bus.op_code      = op;
        bus.a            = x;
        bus.b            = y;
        bus.alu_out      = res;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, 2);
    endtask

    logic [7:0] vec_res [8];

    initial begin
        checks = 0;
        errors = 0;
        vec_res = '{8'h8D, 8'h27, 8'h12, 8'h7B, 8'h69, 8'hA5, 8'hB4, 8'h2D};
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.num_checks   = 8'd0;
        bus.sample_valid = 1'b0;
        bus.a            = 8'd0;
        bus.b            = 8'd0;
        bus.op_code      = 3'd0;
        bus.alu_out      = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass_cnt, 0);
        check("rst_info", bus.err_info, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // all eight ops, back to back, correct results
        start_run(8'd8);
        check("r8_busy", bus.busy, 1);
        for (int i = 0; i < 8; i++)
            send(3'(i), 8'h5A, 8'h33, vec_res[i]);
        check("r8_notdone", bus.done, 0);
        wait_done("r8_lat");
        check("r8_pass", bus.pass_cnt, 8);
        check("r8_fail", bus.fail_cnt, 0);
        check("r8_err", bus.err_flag, 0);

        // one bad add in a run of three
        start_run(8'd3);
        send(3'd2, 8'h0F, 8'h3C, 8'h0C);
        send(3'd0, 8'hF0, 8'h20, 8'h11);
        send(3'd4, 8'hFF, 8'h0F, 8'hF0);
        wait_done("r3_lat");
        check("r3_pass", bus.pass_cnt, 2);
        check("r3_fail", bus.fail_cnt, 1);
        check("r3_err", bus.err_flag, 1);
        check("r3_info", bus.err_info,
              {29'd0, 3'd0, 8'hF0, 8'h20, 8'h11, 8'h10});

        // two bad samples; only the first is latched
        start_run(8'd4);
        send(3'd0, 8'h01, 8'h02, 8'h03);
        send(3'd5, 8'h0F, 8'h00, 8'hF1);
        send(3'd6, 8'h81, 8'h00, 8'h03);
        send(3'd7, 8'h81, 8'h00, 8'h40);
        wait_done("r4_lat");
        check("r4_pass", bus.pass_cnt, 2);
        check("r4_fail", bus.fail_cnt, 2);
        check("r4_info", bus.err_info,
              {29'd0, 3'd5, 8'h0F, 8'h00, 8'hF1, 8'hF0});

        // samples while DONE must not disturb results
        send(3'd0, 8'h01, 8'h01, 8'h00);
        send(3'd0, 8'h01, 8'h01, 8'h02);
        check("dn_pass", bus.pass_cnt, 2);
        check("dn_fail", bus.fail_cnt, 2);
        check("dn_done", bus.done, 1);

        // zero-length run goes straight to DONE with cleared counts
        start_run(8'd0);
        check("z_done", bus.done, 1);
        check("z_pass", bus.pass_cnt, 0);
        check("z_fail", bus.fail_cnt, 0);
        check("z_err", bus.err_flag, 0);

        // start during RUN is ignored
        start_run(8'd2);
        send(3'd3, 8'hA0, 8'h05, 8'hA5);
        start_run(8'd7);
        check("ig_busy", bus.busy, 1);
        send(3'd1, 8'h00, 8'h01, 8'hFF);
        wait_done("ig_lat");
        check("ig_pass", bus.pass_cnt, 2);
        check("ig_fail", bus.fail_cnt, 0);

        // gaps of 0..3 idle cycles between samples
        start_run(8'd5);
        for (int i = 0; i < 5; i++) begin
            send(3'd0, 8'(i), 8'h10, 8'(i + 16));
            for (int g = 0; g < (i % 4); g++) begin
                check("gap_busy", bus.busy, 1);
                @(negedge clk);
            end
        end
        wait_done("gap_lat");
        check("gap_pass", bus.pass_cnt, 5);
        check("gap_fail", bus.fail_cnt, 0);

        // reset mid-run beats start and sample_valid on the same edge
        start_run(8'd6);
        send(3'd2, 8'hFF, 8'h0F, 8'h0F);
        send(3'd2, 8'hFF, 8'h0F, 8'h00);
        rst_n            = 1'b0;
        bus.start        = 1'b1;
        bus.num_checks   = 8'd3;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        check("ra_busy", bus.busy, 0);
        check("ra_done", bus.done, 0);
        check("ra_pass", bus.pass_cnt, 0);
        check("ra_fail", bus.fail_cnt, 0);
        check("ra_err", bus.err_flag, 0);
        check("ra_info", bus.err_info, 0);
        rst_n            = 1'b1;
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check("ra_idle", bus.busy, 0);
        start_run(8'd2);
        send(3'd4, 8'h55, 8'hAA, 8'hFF);
        send(3'd6, 8'h40, 8'h00, 8'h80);
        wait_done("ra_lat");
        check("ra2_pass", bus.pass_cnt, 2);
        check("ra2_fail", bus.fail_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
